// File: rtl/muldiv_unit.sv
// Iterative 32-bit signed multiply / divide / modulo unit for the EX stage.
// One shift-add or shift-subtract step per cycle, 33-cycle fixed latency.
//
// Ports:
//   clk        pipeline clock, rising edge
//   rst        asynchronous active-high reset
//   start      request, sampled only while idle
//   op         00 mul, 01 div, 10 mod, 11 reserved (result 0)
//   op1, op2   signed operands (dividend/multiplicand, divisor/multiplier)
//   flush      synchronous abort back to idle
//   busy       high while computing and during the done cycle
//   done       one-cycle pulse, aluResult valid in the same cycle
//   aluResult  registered result, held until the next completion
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] aluResult
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_MOD = 2'b10;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [31:0] x_q;    // multiplicand, or dividend shifting into quotient
    logic [31:0] y_q;    // multiplier, or divisor
    logic [31:0] acc_q;  // product, or partial remainder
    logic [31:0] op1_q;  // raw op1, returned by mod-by-zero
    logic        neg_q;
    logic        dz_q;
    logic        ovf_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] res_q;

    logic [31:0] x_d;
    logic [31:0] y_d;
    logic [31:0] acc_d;
    logic [31:0] res_d;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] abs1;
    logic [31:0] abs2;

    // |-2^31| wraps to 0x80000000, which is the correct unsigned magnitude
    assign abs1 = op1[31] ? -op1 : op1;
    assign abs2 = op2[31] ? -op2 : op2;

    always_comb begin
        acc_d  = acc_q;
        x_d    = x_q;
        y_d    = y_q;
        rem_sh = {acc_q, x_q[31]};
        diff   = rem_sh - {1'b0, y_q};
        ge     = (rem_sh >= {1'b0, y_q});
        if (op_q == OP_MUL) begin
            if (y_q[0]) begin
                acc_d = acc_q + x_q;
            end
            x_d = {x_q[30:0], 1'b0};
            y_d = {1'b0, y_q[31:1]};
        end else begin
            // restoring step: quotient bit enters x from the bottom
            acc_d = ge ? diff[31:0] : rem_sh[31:0];
            x_d   = {x_q[30:0], ge};
        end
    end

    // final result uses the values produced by the last iteration
    always_comb begin
        res_d = '0;
        unique case (op_q)
            OP_MUL: res_d = neg_q ? -acc_d : acc_d;
            OP_DIV: begin
                if (dz_q)
                    res_d = 32'hFFFF_FFFF;
                else if (ovf_q)
                    res_d = 32'h8000_0000;
                else
                    res_d = neg_q ? -x_d : x_d;
            end
            OP_MOD: begin
                if (dz_q)
                    res_d = op1_q;
                else if (ovf_q)
                    res_d = '0;
                else
                    res_d = neg_q ? -acc_d : acc_d;
            end
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            op1_q   <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        x_q     <= abs1;
                        y_q     <= abs2;
                        op1_q   <= op1;
                        neg_q   <= (op == OP_MOD) ? op1[31] : (op1[31] ^ op2[31]);
                        dz_q    <= (op2 == 32'h0);
                        ovf_q   <= (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    x_q   <= x_d;
                    y_q   <= y_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        res_q   <= res_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign aluResult = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, handshake,
// flush/reset mid-operation and a corner-weighted random sweep.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] aluResult;

    typedef struct {
        logic [31:0] res;
        int          t0;
    } exp_t;

    exp_t        sbq[$];
    int          checks;
    int          errors;
    int          cyc;
    int          done_cnt;
    logic [31:0] last_exp;

    muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .aluResult (aluResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every done pulse must match the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            done_cnt = done_cnt + 1;
            checks = checks + 1;
            if (sbq.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_done result=%h", aluResult);
            end else begin
                e = sbq.pop_front();
                if (aluResult !== e.res || (cyc - e.t0) != 32) begin
                    errors = errors + 1;
                    $display("FAIL result got=%h exp=%h latency_edges got=%0d exp=32",
                             aluResult, e.res, cyc - e.t0);
                end
            end
        end
    end

    function automatic logic [31:0] ref_model(input logic [1:0] o,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [63:0] p;
        sa = a;
        sb = b;
        case (o)
            2'b00: begin
                p = {32'h0, a} * {32'h0, b};
                return p[31:0];
            end
            2'b01: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            2'b10: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] expv);
        checks = checks + 1;
        if (got !== expv) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h", name, got, expv);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv,
                         input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        op1   = a;
        op2   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.res = expv;
            e.t0  = cyc;
            sbq.push_back(e);
            last_exp = expv;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) return;
        end
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL timeout pending=%0d busy=%b", sbq.size(), busy);
        sbq.delete();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    logic [1:0]  dv_op[10];
    logic [31:0] dv_a[10];
    logic [31:0] dv_b[10];
    logic [31:0] dv_r[10];

    initial begin
        int dc0;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        done_cnt = 0;
        last_exp = 32'h0;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        op1   = '0;
        op2   = '0;

        dv_op[0] = 2'b00; dv_a[0] = 32'd7;         dv_b[0] = 32'hFFFF_FFFD; dv_r[0] = 32'hFFFF_FFEB;
        dv_op[1] = 2'b00; dv_a[1] = 32'h0001_0000; dv_b[1] = 32'h0001_0000; dv_r[1] = 32'h0000_0000;
        dv_op[2] = 2'b01; dv_a[2] = 32'hFFFF_FFF9; dv_b[2] = 32'd2;         dv_r[2] = 32'hFFFF_FFFD;
        dv_op[3] = 2'b10; dv_a[3] = 32'hFFFF_FFF9; dv_b[3] = 32'd2;         dv_r[3] = 32'hFFFF_FFFF;
        dv_op[4] = 2'b10; dv_a[4] = 32'd7;         dv_b[4] = 32'hFFFF_FFFE; dv_r[4] = 32'd1;
        dv_op[5] = 2'b01; dv_a[5] = 32'd5;         dv_b[5] = 32'd0;         dv_r[5] = 32'hFFFF_FFFF;
        dv_op[6] = 2'b10; dv_a[6] = 32'd5;         dv_b[6] = 32'd0;         dv_r[6] = 32'd5;
        dv_op[7] = 2'b01; dv_a[7] = 32'h8000_0000; dv_b[7] = 32'hFFFF_FFFF; dv_r[7] = 32'h8000_0000;
        dv_op[8] = 2'b10; dv_a[8] = 32'h8000_0000; dv_b[8] = 32'hFFFF_FFFF; dv_r[8] = 32'h0;
        dv_op[9] = 2'b11; dv_a[9] = 32'd9;         dv_b[9] = 32'd3;         dv_r[9] = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_result", aluResult, 32'h0);

        for (int i = 0; i < 10; i++) begin
            issue(dv_op[i], dv_a[i], dv_b[i], dv_r[i], 1'b1);
            wait_done();
        end

        // start pulsed mid-calculation must be ignored
        dc0 = done_cnt;
        issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        op1   = 32'd3;
        op2   = 32'd4;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        chk("single_done", done_cnt - dc0, 32'd1);

        // flush mid-divide
        issue(2'b01, 32'd1000, 32'd3, 32'h0, 1'b0);
        repeat (14) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'h0, busy}, 32'h0);
        chk("flush_done", {31'h0, done}, 32'h0);
        chk("flush_hold", aluResult, last_exp);
        repeat (40) @(negedge clk);
        chk("flush_hold_late", aluResult, last_exp);
        issue(2'b01, 32'd1000, 32'd3, 32'd333, 1'b1);
        wait_done();

        // asynchronous reset mid-multiply
        issue(2'b00, 32'd12345, 32'd678, 32'h0, 1'b0);
        repeat (19) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_result", aluResult, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        last_exp = 32'h0;
        repeat (40) @(negedge clk);
        chk("rst_quiet", aluResult, 32'h0);
        issue(2'b00, 32'd12345, 32'd678, 32'd8369910, 1'b1);
        wait_done();

        for (int i = 0; i < 1000; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            issue(ro, ra, rb, ref_model(ro, ra, rb), 1'b1);
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
